alu_mul_iter: RTL and testbench

Iterative 32x32 shift-add multiplier with architectural HI/LO registers, sitting directly upstream of the ALU result-select mux in the MIPS execute stage. A multiply is issued with a one-cycle `start` pulse, and the unit retires one partial product per clock. On completion it commits a 64-bit product to HI/LO. `lo` and `hi` feed two data inputs of the 8:1 result mux; the control unit stalls the pipe while `busy` is high.

---
 rtl/alu_mul_pkg.sv | 14 +
 rtl/alu_mul_step.sv | 21 ++
 rtl/alu_mul_iter.sv | 154 +++++++++++++++
 tb/tb_alu_mul_iter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_mul_pkg.sv
// Shared definitions for the iterative HI/LO multiplier: FSM states and sizing constants.
package alu_mul_pkg;

  localparam int unsigned MUL_W     = 32;
  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_step.sv
// One shift-add iteration: conditional add of the multiplicand into the upper half,
// then a zero-filled right shift of the whole accumulator.
module alu_mul_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W:0] acc,
  input  logic [W-1:0] mcand,
  output logic [2*W:0] acc_next_c
);

  logic [W:0] upper_c;

  always_comb begin
    upper_c = acc[2*W:W];
    if (acc[0]) begin
      upper_c = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    end
    acc_next_c = {1'b0, upper_c, acc[W-1:1]};
  end

endmodule

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier with architectural HI/LO registers.
// Optional signed multiply (MULT) enabled by defining ALU_MUL_SIGNED_EN.
module alu_mul_iter
  import alu_mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
`ifdef ALU_MUL_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH + 1;
  localparam int unsigned PRD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  mul_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step_c;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] op_a_c, op_b_c;
  logic             do_neg_c;
`ifdef ALU_MUL_SIGNED_EN
  logic             neg_q, neg_d;
  logic             sign_c;
  logic [PRD_W-1:0] neg_val_c;
`endif

  alu_mul_step #(.W(WIDTH)) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .acc_next_c (acc_step_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    op_a_c   = src_a;
    op_b_c   = src_b;
    do_neg_c = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
    neg_d     = neg_q;
    sign_c    = 1'b0;
    neg_val_c = PRD_W'(0) - acc_q[PRD_W-1:0];
    if (is_signed) begin
      // Magnitude of the most negative value wraps to itself, which is correct unsigned.
      op_a_c = src_a[WIDTH-1] ? (WIDTH'(0) - src_a) : src_a;
      op_b_c = src_b[WIDTH-1] ? (WIDTH'(0) - src_b) : src_b;
      sign_c = src_a[WIDTH-1] ^ src_b[WIDTH-1];
    end
    do_neg_c = neg_q && (acc_step_c[PRD_W-1:0] != PRD_W'(0));
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = op_a_c;
          acc_d   = {(WIDTH + 1)'(0), op_b_c};
          cnt_d   = CNT_W'(0);
          state_d = ST_RUN;
`ifdef ALU_MUL_SIGNED_EN
          neg_d   = sign_c;
`endif
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      ST_RUN: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (do_neg_c) begin
            state_d = ST_NEG;
          end else begin
            hi_d    = acc_step_c[PRD_W-1:WIDTH];
            lo_d    = acc_step_c[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef ALU_MUL_SIGNED_EN
      ST_NEG: begin
        acc_d   = {1'b0, neg_val_c};
        hi_d    = neg_val_c[PRD_W-1:WIDTH];
        lo_d    = neg_val_c[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef ALU_MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mul_iter.sv
// Directed self-checking bench for alu_mul_iter (signed cases only when ALU_MUL_SIGNED_EN is defined).
module tb_alu_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_a, src_b;
`ifdef ALU_MUL_SIGNED_EN
  logic        is_signed;
`endif
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_hi, model_lo;

  alu_mul_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_a     (src_a),
    .src_b     (src_b),
`ifdef ALU_MUL_SIGNED_EN
    .is_signed (is_signed),
`endif
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one multiply and follow it to done; optional write at issue and poke mid-run.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         input bit wr_at_start, input bit poke,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
    int  n;
    bit  stable;
    @(negedge clk);
    src_a = a;
    src_b = b;
`ifdef ALU_MUL_SIGNED_EN
    is_signed = sgn;
`endif
    start = 1'b1;
    if (wr_at_start) begin
      wr_lo   = 1'b1;
      wr_data = 32'h0000_1234;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_lo = 1'b0;
    check("busy_at_issue", 64'(busy), 64'd1);
    check("lo_after_issue", 64'(lo), 64'(model_lo));
    n = 0;
    stable = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (!busy || hi !== model_hi || lo !== model_lo) stable = 1'b0;
      if (poke && n == 5) begin
        start = 1'b1; wr_lo = 1'b1; wr_hi = 1'b1; wr_data = 32'h0000_1234;
        src_a = 32'h1111_1111; src_b = 32'h2222_2222;
      end else begin
        start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
      end
    end
    start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
    check(sgn ? "latency_s" : "latency_u", 64'(n), 64'(exp_lat));
    check("run_stable", 64'(stable), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(exp_hi));
    check("lo", 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_a = '0; src_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
`ifdef ALU_MUL_SIGNED_EN
    is_signed = 1'b0;
`endif
    model_hi = '0;
    model_lo = '0;
    #12;
    check("rst_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0, 32'd15, 32);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    run_mul(32'h0001_0001, 32'd3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0003_0003, 32);
    run_mul(32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA, 32);

    // Idle MTHI then MTLO
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("mthi_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check("mthi_lo_kept", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    model_hi = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0000_0000_CAFE_F00D);
    model_lo = 32'hCAFE_F00D;

    // start wins over a same-cycle MTLO
    run_mul(32'd2, 32'h21, 1'b0, 1'b1, 1'b0, 32'h0, 32'h42, 32);

`ifdef ALU_MUL_SIGNED_EN
    run_mul(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h0, 32);
    run_mul(32'hFFFF_FFFB, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32);
    run_mul(32'd5, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
`endif

    // Asynchronous reset mid-multiply
    @(negedge clk);
    src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0, 32'd42, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
